spi_rx_fifo: RTL and testbench

Receive buffer directly downstream of the SPI slave shift-in stage. Captures each 16-bit word presented with the slave's one-cycle word-complete strobe and queues it in a small FIFO. The CPU/bus side drains the FIFO with a read strobe. Exposes first-word-fall-through data, occupancy, a threshold interrupt, and sticky overflow/underflow flags, so back-to-back SPI words (one every 16 clocks) are never lost while software is slow.

---
 rtl/spi_rx_fifo_pkg.sv | 6 +
 rtl/spi_rx_fifo_if.sv | 27 ++
 rtl/spi_rx_fifo_mem.sv | 21 ++
 rtl/spi_rx_fifo.sv | 68 ++++++
 tb/tb_spi_rx_fifo.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/spi_rx_fifo_pkg.sv
// spi_rx_fifo_pkg: word width and FIFO sizing shared by the SPI slave and its receive buffer
package spi_rx_fifo_pkg;
  localparam int SPI_WORD_WIDTH = 16;
  localparam int SPI_RX_FIFO_DEPTH = 8;
  localparam int SPI_RX_FIFO_THRESHOLD = 4;
endpackage

// File: rtl/spi_rx_fifo_if.sv
// spi_rx_fifo_if: word-strobe input, CPU drain strobe and status outputs of the SPI receive FIFO
interface spi_rx_fifo_if
  import spi_rx_fifo_pkg::*;
#(
  parameter int WIDTH = SPI_WORD_WIDTH,
  parameter int DEPTH = SPI_RX_FIFO_DEPTH
);
  logic                   wordValid;
  logic [WIDTH-1:0]       wordIn;
  logic                   readStrobe;
  logic                   clearFlags;
  logic [WIDTH-1:0]       dataOut;
  logic                   notEmpty;
  logic                   full;
  logic [$clog2(DEPTH):0] count;
  logic                   irq;
  logic                   overflow;
  logic                   underflow;
  modport master (
    output wordValid, wordIn, readStrobe, clearFlags,
    input  dataOut, notEmpty, full, count, irq, overflow, underflow
  );
  modport slave (
    input  wordValid, wordIn, readStrobe, clearFlags,
    output dataOut, notEmpty, full, count, irq, overflow, underflow
  );
endinterface

// File: rtl/spi_rx_fifo_mem.sv
// spi_rx_fifo_mem: DEPTH x WIDTH register array, one write port, one asynchronous read port
module spi_rx_fifo_mem
  import spi_rx_fifo_pkg::*;
#(
  parameter int WIDTH = SPI_WORD_WIDTH,
  parameter int DEPTH = SPI_RX_FIFO_DEPTH
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  // storage is deliberately not reset; emptiness is tracked by the parent's count
  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: queues SPI slave words on strobe rising edges, drained by a CPU read strobe
module spi_rx_fifo
  import spi_rx_fifo_pkg::*;
#(
  parameter int WIDTH     = SPI_WORD_WIDTH,
  parameter int DEPTH     = SPI_RX_FIFO_DEPTH,
  parameter int THRESHOLD = SPI_RX_FIFO_THRESHOLD
) (
  input logic          clock,
  input logic          resetN,
  spi_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_prev_q, valid_prev_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             push, pop, we, not_empty, is_full;
  logic [WIDTH-1:0] rd_data;
  // next state: a pop on a full FIFO makes room for a simultaneous push; set beats clear on the flags
  always_comb begin
    not_empty    = count_q != '0;
    is_full      = count_q == CW'(DEPTH);
    push         = bus.wordValid & ~valid_prev_q;
    pop          = bus.readStrobe & not_empty;
    we           = push & (~is_full | pop);
    valid_prev_d = bus.wordValid;
    wr_ptr_d     = we ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d      = count_q + CW'(we) - CW'(pop);
    overflow_d   = (push & ~we) | (overflow_q & ~bus.clearFlags);
    underflow_d  = (bus.readStrobe & ~not_empty) | (underflow_q & ~bus.clearFlags);
  end
  // state registers; reset discards everything queued
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      valid_prev_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      valid_prev_q <= valid_prev_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end
  spi_rx_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clock (clock),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (bus.wordIn),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );
  assign bus.dataOut   = not_empty ? rd_data : '0;
  assign bus.notEmpty  = not_empty;
  assign bus.full      = is_full;
  assign bus.count     = count_q;
  assign bus.irq       = count_q >= CW'(THRESHOLD);
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_spi_rx_fifo.sv
// tb_spi_rx_fifo: directed checks of the SPI receive FIFO
module tb_spi_rx_fifo;
  logic clock;
  logic resetN;
  int   tests = 0;
  int   fails = 0;
  spi_rx_fifo_if #(.WIDTH(16), .DEPTH(8)) bif ();
  spi_rx_fifo #(.WIDTH(16), .DEPTH(8), .THRESHOLD(4)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bif)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic push(input logic [15:0] w);
    bif.wordIn = w;
    bif.wordValid = 1'b1;
    tick();
    bif.wordValid = 1'b0;
    tick();
  endtask
  task automatic pop();
    bif.readStrobe = 1'b1;
    tick();
    bif.readStrobe = 1'b0;
  endtask
  task automatic clear();
    bif.clearFlags = 1'b1;
    tick();
    bif.clearFlags = 1'b0;
  endtask
  initial begin
    resetN = 1'b0;
    bif.wordValid = 1'b0;
    bif.wordIn = '0;
    bif.readStrobe = 1'b0;
    bif.clearFlags = 1'b0;
    tick();
    tick();
    chk("rst_count", bif.count, 0);
    chk("rst_notEmpty", bif.notEmpty, 0);
    chk("rst_full", bif.full, 0);
    chk("rst_dataOut", bif.dataOut, 0);
    chk("rst_irq", bif.irq, 0);
    chk("rst_flags", {bif.overflow, bif.underflow}, 0);
    resetN = 1'b1;
    tick();
    push(16'hA55A);
    chk("single_notEmpty", bif.notEmpty, 1);
    chk("single_count", bif.count, 1);
    chk("single_data", bif.dataOut, 16'hA55A);
    pop();
    chk("single_pop_count", bif.count, 0);
    chk("single_pop_data", bif.dataOut, 0);
    chk("single_pop_notEmpty", bif.notEmpty, 0);
    bif.wordIn = 16'h1234;
    bif.wordValid = 1'b1;
    repeat (5) tick();
    bif.wordValid = 1'b0;
    tick();
    chk("held_count", bif.count, 1);
    chk("held_data", bif.dataOut, 16'h1234);
    pop();
    chk("held_drain", bif.count, 0);
    for (int i = 1; i <= 9; i++) begin
      push(16'(i));
      repeat (14) tick();
    end
    chk("ovf_full", bif.full, 1);
    chk("ovf_count", bif.count, 8);
    chk("ovf_flag", bif.overflow, 1);
    chk("ovf_irq", bif.irq, 1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("ovf_drain%0d", i), bif.dataOut, i);
      pop();
    end
    chk("ovf_empty_count", bif.count, 0);
    chk("ovf_empty_data", bif.dataOut, 0);
    chk("ovf_no_underflow", bif.underflow, 0);
    clear();
    chk("ovf_cleared", bif.overflow, 0);
    for (int i = 0; i < 8; i++) push(16'(16'h0010 + i));
    chk("fullpp_pre_count", bif.count, 8);
    bif.wordIn = 16'hBEEF;
    bif.wordValid = 1'b1;
    bif.readStrobe = 1'b1;
    tick();
    bif.wordValid = 1'b0;
    bif.readStrobe = 1'b0;
    tick();
    chk("fullpp_count", bif.count, 8);
    chk("fullpp_full", bif.full, 1);
    chk("fullpp_no_ovf", bif.overflow, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fullpp_drain%0d", i), bif.dataOut, (i < 7) ? 32'h11 + i : 32'hBEEF);
      pop();
    end
    chk("fullpp_empty", bif.count, 0);
    bif.wordIn = 16'h5A5A;
    bif.wordValid = 1'b1;
    bif.readStrobe = 1'b1;
    tick();
    bif.wordValid = 1'b0;
    bif.readStrobe = 1'b0;
    tick();
    chk("emptypp_count", bif.count, 1);
    chk("emptypp_underflow", bif.underflow, 1);
    chk("emptypp_data", bif.dataOut, 16'h5A5A);
    pop();
    clear();
    chk("emptypp_cleared", bif.underflow, 0);
    chk("emptypp_drained", bif.count, 0);
    pop();
    chk("unf_flag", bif.underflow, 1);
    chk("unf_count", bif.count, 0);
    bif.clearFlags = 1'b1;
    bif.readStrobe = 1'b1;
    tick();
    bif.clearFlags = 1'b0;
    bif.readStrobe = 1'b0;
    chk("unf_set_wins", bif.underflow, 1);
    clear();
    chk("unf_cleared", bif.underflow, 0);
    push(16'h0A01);
    push(16'h0A02);
    push(16'h0A03);
    chk("irq_below", bif.irq, 0);
    bif.wordIn = 16'h0A04;
    bif.wordValid = 1'b1;
    tick();
    bif.wordValid = 1'b0;
    chk("irq_rise", bif.irq, 1);
    chk("irq_count", bif.count, 4);
    tick();
    pop();
    chk("irq_fall", bif.irq, 0);
    chk("irq_pop_count", bif.count, 3);
    chk("irq_head", bif.dataOut, 16'h0A02);
    #2;
    resetN = 1'b0;
    #1;
    chk("midrst_count", bif.count, 0);
    chk("midrst_notEmpty", bif.notEmpty, 0);
    chk("midrst_data", bif.dataOut, 0);
    tick();
    resetN = 1'b1;
    #2;
    push(16'hC0DE);
    chk("post_rst_count", bif.count, 1);
    chk("post_rst_data", bif.dataOut, 16'hC0DE);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
